// File: rtl/autocorr_sequencer.sv
// Sequential autocorrelation engine. One AND/accumulate datapath is shared across all (lag, term) pairs,
// and the results land in a small register bank. Define AUTOCORR_SEQ_MIRROR_EN to serve mirrored lags at N..2N-2.
module autocorr_sequencer #(
    parameter int N = 3,
    parameter int W = 2,
    localparam int AW = $clog2(2*N-1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  in,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] res_addr,
    output logic [W-1:0]  res_data
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  win;
    logic [W-1:0]  acc;
    logic [CW-1:0] k;
    logic [CW-1:0] j;
    logic [CW-1:0] partner;
    logic [W-1:0]  res [N];
    logic          term;
    logic          last_term;
    logic          last_lag;

    // Lag k pairs bit j with bit N-1-k+j; j never exceeds k, so partner stays inside the window.
    assign partner   = CW'(N-1) - k + j;
    assign term      = win[j] & win[partner];
    assign last_term = (j == k);
    assign last_lag  = (k == CW'(N-1));

    // NOTE: sequential state uses <= so every flop samples values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_term && last_lag) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win <= '0;
            acc <= '0;
            k   <= '0;
            j   <= '0;
        end else if (state == IDLE && start) begin
            win <= in;
            acc <= '0;
            k   <= '0;
            j   <= '0;
        end else if (state == CALC) begin
            if (!last_term) begin
                acc <= acc + W'(term);
                j   <= j + CW'(1);
            end else begin
                acc <= '0;
                j   <= '0;
                k   <= last_lag ? '0 : k + CW'(1);
            end
        end
    end

    // NOTE: the bank is a handful of flops, so it is reset; an aborted run then leaves no stale partial results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                res[i] <= '0;
            end
        end else if (state == CALC && last_term) begin
            res[k] <= acc + W'(term);
        end
    end

`ifdef AUTOCORR_SEQ_MIRROR_EN
    logic [CW-1:0] mirror_idx;

    // 2N-2-addr always fits in CW bits for the mirrored range, so modular subtraction is exact.
    assign mirror_idx = CW'(2*N-2) - res_addr[CW-1:0];

    always_comb begin
        res_data = '0;
        if (res_addr < AW'(N)) begin
            res_data = res[res_addr[CW-1:0]];
        end else if (res_addr <= AW'(2*N-2)) begin
            res_data = res[mirror_idx];
        end
    end
`else
    always_comb begin
        res_data = '0;
        if (res_addr < AW'(N)) begin
            res_data = res[res_addr[CW-1:0]];
        end
    end
`endif

endmodule
